// File: rtl/seqdet_rr_sched.sv
// seqdet_rr_sched: round-robin time-shared two-consecutive-ones Mealy detector over NCH bit channels
// Ports: Clock (rising edge), Resetn (sync, active-low)
//   Req/Bit/Clear [NCH]: per-channel pending flag, bit value, force-to-A
//   Gnt [NCH]: combinational one-hot grant, a bit is consumed when Req&Gnt
//   zValid/z/zCh: registered result of the grant consumed last cycle
//   CntSel/CntVal: per-channel saturating match counter readback, present only with SEQDET_MATCH_CNT_EN
module seqdet_rr_sched #(
  parameter int NCH = 4,
  parameter int IDW = 2
`ifdef SEQDET_MATCH_CNT_EN
  , parameter int CNTW = 8
`endif
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [NCH-1:0]   Req,
  input  logic [NCH-1:0]   Bit,
  input  logic [NCH-1:0]   Clear,
  output logic [NCH-1:0]   Gnt,
  output logic             zValid,
  output logic             z,
  output logic [IDW-1:0]   zCh
`ifdef SEQDET_MATCH_CNT_EN
  , input  logic [IDW-1:0] CntSel,
  output logic [CNTW-1:0]  CntVal
`endif
);
  logic [NCH-1:0] y, y_nxt, elig;
  logic [IDW-1:0] ptr, g, idx;
  logic           hit, match;
  // clear masks a channel and reset holds every grant off
  assign elig = Req & ~Clear & {NCH{Resetn}};
  always_comb begin
    Gnt = '0;
    g = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = IDW'((int'(ptr) + k >= NCH) ? int'(ptr) + k - NCH : int'(ptr) + k);
      if (!hit && elig[idx]) begin
        Gnt[idx] = 1'b1;
        g = idx;
        hit = 1'b1;
      end
    end
  end
  assign match = hit & y[g] & Bit[g];
  always_comb begin
    y_nxt = y & ~Clear;
    if (hit) y_nxt[g] = Bit[g];
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      y <= '0;
      ptr <= '0;
      zValid <= 1'b0;
      z <= 1'b0;
      zCh <= '0;
    end else begin
      y <= y_nxt;
      zValid <= hit;
      z <= match;
      if (hit) begin
        zCh <= g;
        ptr <= (g == IDW'(NCH - 1)) ? '0 : g + 1'b1;
      end
    end
  end
`ifdef SEQDET_MATCH_CNT_EN
  logic [CNTW-1:0] cnt [NCH];
  always_ff @(posedge Clock) begin
    for (int i = 0; i < NCH; i++)
      if (!Resetn || Clear[i]) cnt[i] <= '0;
      else if (match && g == IDW'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
  end
  assign CntVal = (int'(CntSel) < NCH) ? cnt[CntSel] : '0;
`endif
endmodule

// File: tb/tb_seqdet_rr_sched.sv
// tb_seqdet_rr_sched: directed self-checking bench for seqdet_rr_sched
module tb_seqdet_rr_sched;
  localparam int NCH = 4;
  localparam int IDW = 2;
  logic           Clock = 1'b0;
  logic           Resetn = 1'b0;
  logic [NCH-1:0] Req = '0, Bit = '0, Clear = '0, Gnt;
  logic           zValid, z;
  logic [IDW-1:0] zCh;
`ifdef SEQDET_MATCH_CNT_EN
  logic [IDW-1:0] CntSel = '0;
  logic [7:0]     CntVal;
`endif
  int n_cmp = 0, n_err = 0;
  logic [4:0] t1_bits = 5'b10111;
  logic [4:0] t1_z    = 5'b00110;
  always #5 Clock = ~Clock;
  seqdet_rr_sched #(.NCH(NCH), .IDW(IDW)) dut (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .Bit(Bit), .Clear(Clear),
    .Gnt(Gnt), .zValid(zValid), .z(z), .zCh(zCh)
`ifdef SEQDET_MATCH_CNT_EN
    , .CntSel(CntSel), .CntVal(CntVal)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask
  task automatic do_reset();
    Resetn = 1'b0;
    Req = '0;
    Clear = '0;
    cyc();
    cyc();
    Resetn = 1'b1;
  endtask
  task automatic grant(input string tag, input logic [3:0] rq, input logic [3:0] bt,
                       input logic [3:0] eg, input logic ez, input logic [1:0] ech);
    Req = rq;
    Bit = bt;
    #1;
    chk({tag, " gnt"}, 32'(Gnt), 32'(eg));
    cyc();
    chk({tag, " zvalid"}, 32'(zValid), 32'd1);
    chk({tag, " z"}, 32'(z), 32'(ez));
    chk({tag, " zch"}, 32'(zCh), 32'(ech));
  endtask
  initial begin
    Req = 4'hF;
    Bit = 4'hF;
    #2;
    chk("rst gnt", 32'(Gnt), 32'd0);
    cyc();
    chk("rst zvalid", 32'(zValid), 32'd0);
    chk("rst z", 32'(z), 32'd0);
    chk("rst zch", 32'(zCh), 32'd0);
    cyc();
    Resetn = 1'b1;
    Req = '0;
    for (int i = 0; i < 5; i++)
      grant("t1", 4'b0001, {3'b000, t1_bits[i]}, 4'b0001, t1_z[i], 2'd0);
    Req = '0;
    #1;
    chk("idle gnt", 32'(Gnt), 32'd0);
    cyc();
    chk("idle zvalid", 32'(zValid), 32'd0);
    chk("idle z", 32'(z), 32'd0);
    chk("idle zch", 32'(zCh), 32'd0);
    do_reset();
    for (int i = 0; i < 8; i++)
      grant("t2", 4'hF, 4'hF, 4'(4'b0001 << (i % 4)), i >= 4, 2'(i % 4));
    do_reset();
    grant("t3a", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    grant("t3b", 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd1);
    grant("t3c", 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0);
    grant("t4a", 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd2);
    Clear = 4'b0100;
    Req = 4'b0100;
    #1;
    chk("t4 clr gnt", 32'(Gnt), 32'd0);
    cyc();
    chk("t4 clr zvalid", 32'(zValid), 32'd0);
    Clear = '0;
    grant("t4b", 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd2);
    grant("t4c", 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0);
    Clear = 4'b0010;
    grant("t4d", 4'b0011, 4'b0011, 4'b0001, 1'b1, 2'd0);
    Clear = '0;
    grant("t5a", 4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd1);
    Resetn = 1'b0;
    #1;
    chk("t5 rst gnt0", 32'(Gnt), 32'd0);
    cyc();
    chk("t5 rst zvalid0", 32'(zValid), 32'd0);
    chk("t5 rst zch", 32'(zCh), 32'd0);
    #1;
    chk("t5 rst gnt1", 32'(Gnt), 32'd0);
    cyc();
    chk("t5 rst zvalid1", 32'(zValid), 32'd0);
    Resetn = 1'b1;
    grant("t5b", 4'b0010, 4'b0010, 4'b0010, 1'b0, 2'd1);
`ifdef SEQDET_MATCH_CNT_EN
    do_reset();
    CntSel = 2'd3;
    for (int i = 0; i < 262; i++) begin
      Req = 4'b1000;
      Bit = 4'b1000;
      cyc();
      if (i == 9) chk("t6 cnt9", 32'(CntVal), 32'd9);
    end
    Req = '0;
    #1;
    chk("t6 sat", 32'(CntVal), 32'd255);
    Clear = 4'b1000;
    cyc();
    chk("t6 clr", 32'(CntVal), 32'd0);
    Clear = '0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
